// File: rtl/cdce_serial_pkg.sv
// Shared types and constants for the CDCE serial command engine.
// Contents: FSM state enum, default parameter values, chip-select
// index width helper.
package cdce_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_CS_COUNT   = 1;
  localparam int unsigned DEF_CLK_DIV    = 2;
  localparam int unsigned DEF_GAP_CYCLES = 1;

  // Width of the chip-select index; a single select still needs one bit.
  function automatic int unsigned cs_sel_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdce_serial_xfer_if.sv
// Bus bundle between a command issuer (master) and the serial engine (slave).
// Request side: enable, start_transaction, cs_select, parallel_input.
// Serial side: miso in; cs_n, sclk, mosi out.
// Status side: busy, transaction_done, read_data.
interface cdce_serial_xfer_if
  import cdce_serial_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned CS_COUNT = DEF_CS_COUNT
) ();

  localparam int unsigned SEL_W = cs_sel_w(CS_COUNT);

  logic                enable;
  logic                start_transaction;
  logic [SEL_W-1:0]    cs_select;
  logic [DATA_W-1:0]   parallel_input;
  logic                miso;
  logic [CS_COUNT-1:0] cs_n;
  logic                sclk;
  logic                mosi;
  logic                busy;
  logic                transaction_done;
  logic [DATA_W-1:0]   read_data;

  modport master (
    output enable, start_transaction, cs_select, parallel_input, miso,
    input  cs_n, sclk, mosi, busy, transaction_done, read_data
  );

  modport slave (
    input  enable, start_transaction, cs_select, parallel_input, miso,
    output cs_n, sclk, mosi, busy, transaction_done, read_data
  );

endinterface

// File: rtl/cdce_sclk_gen.sv
// SCLK divider: CLK_DIV cycles low then CLK_DIV cycles high per bit.
// Ports: clk, reset (sync, active-high), en (restarts low when deasserted),
//        sclk (registered), rise_tick_c / fall_tick_c (strobes marking the
//        edge on which sclk rises / falls).
module cdce_sclk_gen
  import cdce_serial_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise_tick_c,
  output logic fall_tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             half_end_c;

  // Last cycle of the current half-period.
  assign half_end_c  = en && (cnt == CNT_MAX);
  assign rise_tick_c = half_end_c && !sclk;
  assign fall_tick_c = half_end_c && sclk;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cdce_serial_xfer.sv
// SPI mode-0 command engine: shifts a DATA_W word MSB-first on mosi while
// capturing miso, on one of CS_COUNT active-low chip selects.
// Ports: clk, reset (sync, active-high), bus (cdce_serial_xfer_if.slave).
module cdce_serial_xfer
  import cdce_serial_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned CS_COUNT   = DEF_CS_COUNT,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input logic               clk,
  input logic               reset,
  cdce_serial_xfer_if.slave bus
);

  localparam int unsigned SEL_W = cs_sel_w(CS_COUNT);
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  state_e              state, state_d;
  logic [BIT_W-1:0]    bit_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [DATA_W-1:0]   tx_sr, rx_sr, read_data_q;
  logic [SEL_W-1:0]    sel_q;
  logic [CS_COUNT-1:0] cs_n_q, cs_n_d;
  logic                busy_q, done_q;
  logic                accept_c, shift_end_c, gap_end_c;
  logic                sclk_q, rise_tick_c, fall_tick_c;

  cdce_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk         (clk),
    .reset       (reset),
    .en          (state == SHIFT),
    .sclk        (sclk_q),
    .rise_tick_c (rise_tick_c),
    .fall_tick_c (fall_tick_c)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state;
    accept_c    = 1'b0;
    shift_end_c = 1'b0;
    gap_end_c   = 1'b0;
    cs_n_d      = '1;
    case (state)
      IDLE: begin
        if (bus.start_transaction && bus.enable &&
            (32'(bus.cs_select) < CS_COUNT)) begin
          accept_c = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // Bit 0 ends on its falling sclk edge.
        if (fall_tick_c && (bit_cnt == '0)) begin
          shift_end_c = 1'b1;
          state_d     = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          gap_end_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == SHIFT) begin
      cs_n_d = ~(CS_COUNT'(1) << (accept_c ? bus.cs_select : sel_q));
    end
  end

  // State, counters and shift registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      read_data_q <= '0;
      sel_q       <= '0;
      cs_n_q      <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state  <= state_d;
      cs_n_q <= cs_n_d;
      busy_q <= (state_d != IDLE);
      done_q <= gap_end_c;

      // TX shifts in zeros, so mosi reads 0 once the word is out.
      if (accept_c) begin
        tx_sr   <= bus.parallel_input;
        sel_q   <= bus.cs_select;
        bit_cnt <= BIT_W'(DATA_W - 1);
      end else if (fall_tick_c) begin
        tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
        bit_cnt <= bit_cnt - BIT_W'(1);
      end

      if (rise_tick_c) begin
        rx_sr <= {rx_sr[DATA_W-2:0], bus.miso};
      end

      if (shift_end_c) begin
        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end

      if (gap_end_c) begin
        read_data_q <= rx_sr;
      end
    end
  end

  assign bus.cs_n             = cs_n_q;
  assign bus.sclk             = sclk_q;
  assign bus.mosi             = tx_sr[DATA_W-1];
  assign bus.busy             = busy_q;
  assign bus.transaction_done = done_q;
  assign bus.read_data        = read_data_q;

endmodule

// File: tb/tb_cdce_serial_xfer.sv
// Bench for cdce_serial_xfer: two configurations run in lockstep against a
// cycle-indexed reference model derived from the transaction timeline.
// A: DATA_W=32, CS_COUNT=3, CLK_DIV=2, GAP_CYCLES=1
// B: DATA_W=20, CS_COUNT=1, CLK_DIV=1, GAP_CYCLES=4
module tb_cdce_serial_xfer;
  import cdce_serial_pkg::*;

  localparam int DW_A = 32, CS_A = 3, CD_A = 2, GP_A = 1;
  localparam int DW_B = 20, CS_B = 1, CD_B = 1, GP_B = 4;
  localparam int SW_A = cs_sel_w(CS_A);
  localparam int SW_B = cs_sel_w(CS_B);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus per DUT (index 0 = A, 1 = B).
  logic        rst[2], en[2], st[2], loop[2], miso_r[2];
  int          sel[2];
  logic [63:0] din[2];

  // Reference model: mk = cycles since acceptance (0 = idle).
  int          mk[2], msel[2];
  logic [63:0] mw[2], mrx[2], mrd[2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  cdce_serial_xfer_if #(.DATA_W(DW_A), .CS_COUNT(CS_A)) ifa ();
  cdce_serial_xfer_if #(.DATA_W(DW_B), .CS_COUNT(CS_B)) ifb ();

  assign ifa.enable            = en[0];
  assign ifa.start_transaction = st[0];
  assign ifa.cs_select         = SW_A'(sel[0]);
  assign ifa.parallel_input    = DW_A'(din[0]);
  assign ifa.miso              = loop[0] ? ifa.mosi : miso_r[0];
  assign ifb.enable            = en[1];
  assign ifb.start_transaction = st[1];
  assign ifb.cs_select         = SW_B'(sel[1]);
  assign ifb.parallel_input    = DW_B'(din[1]);
  assign ifb.miso              = loop[1] ? ifb.mosi : miso_r[1];

  cdce_serial_xfer #(.DATA_W(DW_A), .CS_COUNT(CS_A), .CLK_DIV(CD_A), .GAP_CYCLES(GP_A))
    dut_a (.clk(clk), .reset(rst[0]), .bus(ifa));
  cdce_serial_xfer #(.DATA_W(DW_B), .CS_COUNT(CS_B), .CLK_DIV(CD_B), .GAP_CYCLES(GP_B))
    dut_b (.clk(clk), .reset(rst[1]), .bus(ifb));

  function automatic int dw(int d);  return (d == 0) ? DW_A : DW_B; endfunction
  function automatic int cd(int d);  return (d == 0) ? CD_A : CD_B; endfunction
  function automatic int gp(int d);  return (d == 0) ? GP_A : GP_B; endfunction
  function automatic int ncs(int d); return (d == 0) ? CS_A : CS_B; endfunction
  function automatic int sh(int d);  return 2 * cd(d) * dw(d); endfunction
  function automatic int tot(int d); return sh(d) + gp(d) + 1; endfunction
  function automatic logic [63:0] mask(int n); return (64'd1 << n) - 64'd1; endfunction

  function automatic logic shifting(int d);
    return (mk[d] >= 1) && (mk[d] <= sh(d));
  endfunction
  function automatic logic [63:0] exp_cs(int d);
    return shifting(d) ? (mask(ncs(d)) & ~(64'd1 << msel[d])) : mask(ncs(d));
  endfunction
  function automatic logic exp_sclk(int d);
    return shifting(d) && (((mk[d] - 1) % (2 * cd(d))) >= cd(d));
  endfunction
  function automatic logic exp_mosi(int d);
    if (!shifting(d)) return 1'b0;
    return mw[d][dw(d) - 1 - (mk[d] - 1) / (2 * cd(d))];
  endfunction

  function automatic logic [63:0] obs_cs(int d);
    return (d == 0) ? 64'(ifa.cs_n) : 64'(ifb.cs_n);
  endfunction
  function automatic logic obs_sclk(int d); return (d == 0) ? ifa.sclk : ifb.sclk; endfunction
  function automatic logic obs_mosi(int d); return (d == 0) ? ifa.mosi : ifb.mosi; endfunction
  function automatic logic obs_busy(int d); return (d == 0) ? ifa.busy : ifb.busy; endfunction
  function automatic logic obs_done(int d);
    return (d == 0) ? ifa.transaction_done : ifb.transaction_done;
  endfunction
  function automatic logic [63:0] obs_rd(int d);
    return (d == 0) ? 64'(ifa.read_data) : 64'(ifb.read_data);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: sample miso / acceptance, advance the model, compare all outputs.
  task automatic step();
    logic acc[2];
    logic m;
    for (int d = 0; d < 2; d++) begin
      if (!rst[d] && shifting(d) && (((mk[d] - 1) % (2 * cd(d))) == cd(d) - 1)) begin
        m = loop[d] ? exp_mosi(d) : miso_r[d];
        mrx[d] = {mrx[d][62:0], m};
      end
      acc[d] = st[d] && en[d] && (sel[d] < ncs(d)) && ((mk[d] == 0) || (mk[d] == tot(d)));
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        mk[d]  = 0;
        mrd[d] = '0;
      end else if (acc[d]) begin
        mk[d]   = 1;
        mw[d]   = din[d] & mask(dw(d));
        msel[d] = sel[d];
        mrx[d]  = '0;
      end else if ((mk[d] >= 1) && (mk[d] < tot(d))) begin
        mk[d]++;
        if (mk[d] == tot(d)) mrd[d] = mrx[d] & mask(dw(d));
      end else begin
        mk[d] = 0;
      end
      chk(d == 0 ? "A.cs_n" : "B.cs_n", obs_cs(d), exp_cs(d));
      chk(d == 0 ? "A.sclk" : "B.sclk", 64'(obs_sclk(d)), 64'(exp_sclk(d)));
      chk(d == 0 ? "A.mosi" : "B.mosi", 64'(obs_mosi(d)), 64'(exp_mosi(d)));
      chk(d == 0 ? "A.busy" : "B.busy", 64'(obs_busy(d)),
          64'((mk[d] >= 1) && (mk[d] < tot(d))));
      chk(d == 0 ? "A.done" : "B.done", 64'(obs_done(d)), 64'(mk[d] == tot(d)));
      chk(d == 0 ? "A.read_data" : "B.read_data", obs_rd(d), mrd[d]);
    end
  endtask

  initial begin
    int lowa, lowb, donea, doneb, togb, highs, ndone, nlow;
    logic prev;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; en[d] = 1'b1; st[d] = 1'b0; loop[d] = 1'b0; miso_r[d] = 1'b0;
      sel[d] = 0; din[d] = '0; mk[d] = 0; msel[d] = 0;
      mw[d] = '0; mrx[d] = '0; mrd[d] = '0;
    end
    step(); step();
    rst[0] = 1'b0; rst[1] = 1'b0;
    step();

    // Single write on A; corner configuration on B.
    cyc = 0;
    din[0] = 64'hA5A5_0F0F; din[1] = 64'({$urandom} & 32'hF_FFFF);
    st[0] = 1'b1; st[1] = 1'b1;
    lowa = 0; lowb = 0; donea = -1; doneb = -1; togb = 0; prev = 1'b0;
    for (int n = 1; n <= 150; n++) begin
      miso_r[0] = 1'($urandom); miso_r[1] = 1'($urandom);
      step();
      st[0] = 1'b0; st[1] = 1'b0;
      if (ifa.cs_n[0] == 1'b0) lowa++;
      if (ifb.cs_n[0] == 1'b0) lowb++;
      if (ifa.transaction_done) donea = n;
      if (ifb.transaction_done) doneb = n;
      if ((n >= 2) && (n <= 40) && (ifb.sclk != prev)) togb++;
      prev = ifb.sclk;
    end
    chk("A.cs0_low_cycles", 64'(lowa), 64'd128);
    chk("A.done_cycle", 64'(donea), 64'd130);
    chk("B.cs_low_cycles", 64'(lowb), 64'd40);
    chk("B.done_cycle", 64'(doneb), 64'd45);
    chk("B.sclk_toggles", 64'(togb), 64'd39);

    // Loopback on both DUTs.
    loop[0] = 1'b1; loop[1] = 1'b1;
    din[0] = 64'h1234_5678; din[1] = 64'({$urandom} & 32'hF_FFFF);
    st[0] = 1'b1; st[1] = 1'b1;
    for (int n = 1; n <= 130; n++) begin
      step();
      st[0] = 1'b0; st[1] = 1'b0;
    end
    chk("A.loopback_done", 64'(ifa.transaction_done), 64'd1);
    chk("A.loopback_data", 64'(ifa.read_data), 64'h1234_5678);
    chk("B.loopback_data", 64'(ifb.read_data), din[1]);
    loop[0] = 1'b0; loop[1] = 1'b0;
    step();

    // Back-to-back with start held high.
    din[0] = 64'hDEAD_BEEF; st[0] = 1'b1; highs = 0;
    for (int n = 1; n <= 131; n++) begin
      step();
      din[0] = 64'h0BAD_F00D;
      if ((n >= 2) && ifa.cs_n[0]) highs++;
      if (n == 130) chk("A.b2b_cs_high_130", 64'(ifa.cs_n[0]), 64'd1);
      if (n == 131) chk("A.b2b_cs_low_131", 64'(ifa.cs_n[0]), 64'd0);
    end
    st[0] = 1'b0;
    chk("A.b2b_gap_cycles", 64'(highs), 64'd2);
    repeat (132) step();

    // enable low: no acceptance.
    en[0] = 1'b0; st[0] = 1'b1; ndone = 0; nlow = 0;
    repeat (20) begin
      step();
      if (ifa.transaction_done) ndone++;
      if (ifa.cs_n != 3'b111) nlow++;
    end
    chk("A.gated_done", 64'(ndone), 64'd0);
    chk("A.gated_cs_low", 64'(nlow), 64'd0);
    en[0] = 1'b1; st[0] = 1'b0;

    // cs_select 2 drives only cs_n[2]; 3 is out of range.
    sel[0] = 2; din[0] = {$urandom, $urandom}; st[0] = 1'b1;
    step(); st[0] = 1'b0;
    chk("A.sel2_cs_n", 64'(ifa.cs_n), 64'b011);
    repeat (130) step();
    sel[0] = 3; st[0] = 1'b1;
    step(); st[0] = 1'b0;
    chk("A.sel3_cs_n", 64'(ifa.cs_n), 64'b111);
    chk("A.sel3_busy", 64'(ifa.busy), 64'd0);
    repeat (3) step();
    sel[0] = 0;

    // Reset at cycle 40 of a transfer.
    din[0] = {$urandom, $urandom}; st[0] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      miso_r[0] = 1'($urandom);
      step(); st[0] = 1'b0;
    end
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("A.rst_cs_n", 64'(ifa.cs_n), 64'b111);
    chk("A.rst_sclk", 64'(ifa.sclk), 64'd0);
    chk("A.rst_busy", 64'(ifa.busy), 64'd0);
    chk("A.rst_read_data", 64'(ifa.read_data), 64'd0);
    chk("A.rst_done", 64'(ifa.transaction_done), 64'd0);
    din[0] = {$urandom, $urandom}; st[0] = 1'b1;
    for (int n = 1; n <= 130; n++) begin
      miso_r[0] = 1'($urandom);
      step(); st[0] = 1'b0;
    end
    chk("A.post_rst_done", 64'(ifa.transaction_done), 64'd1);

    // Randomized traffic on both DUTs.
    repeat (1500) begin
      for (int d = 0; d < 2; d++) begin
        rst[d]    = ($urandom_range(0, 599) == 0);
        en[d]     = ($urandom_range(0, 7) != 0);
        st[d]     = ($urandom_range(0, 3) == 0);
        sel[d]    = int'($urandom_range(0, (d == 0) ? 3 : 1));
        din[d]    = {$urandom, $urandom};
        miso_r[d] = 1'($urandom);
        loop[d]   = ($urandom_range(0, 9) == 0);
      end
      step();
    end
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; st[d] = 1'b0; loop[d] = 1'b0;
    end
    repeat (150) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
